instr_fetch_unit: RTL

Sequential instruction fetch stage that produces the instruction stream consumed by the main control unit. It holds the program counter, fetches 32-bit MIPS instructions from instruction memory over a req/ack handshake, and presents the instruction register and its opcode field. After the datapath signals completion, it computes the next PC from the `Branch`, `Jump` and `Zero` resolution signals.

---
 rtl/instr_fetch_unit_if.sv | 21 ++
 rtl/instr_fetch_unit.sv | 87 ++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch stage: PC, instruction register and next-PC selection,
// sequenced by a BOOT/FETCH/EXEC state machine over a req/ack imem handshake.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_unit_if.master   imem,
    output logic [31:0]          instr,
    output logic [5:0]           op,
    output logic                 instr_valid,
    output logic [31:0]          pc,
    input  logic                 Branch,
    input  logic                 Jump,
    input  logic                 Zero,
    input  logic                 exec_done,
    output logic [CNT_W-1:0]     retire_cnt
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t state;

    // Jump takes priority over a taken branch; all arithmetic wraps at 32 bits.
    function automatic logic [31:0] next_pc_f(
        input logic [31:0] pc_cur,
        input logic [31:0] ir,
        input logic        br,
        input logic        jmp,
        input logic        zr
    );
        logic        [31:0] pc4;
        logic signed [31:0] br_off;
        pc4    = pc_cur + 32'd4;
        br_off = signed'({{14{ir[15]}}, ir[15:0], 2'b00});
        if (jmp)
            next_pc_f = {pc4[31:28], ir[25:0], 2'b00};
        else if (br && zr)
            next_pc_f = pc4 + $unsigned(br_off);
        else
            next_pc_f = pc4;
    endfunction

    assign imem.imem_req  = (state == S_FETCH);
    assign imem.imem_addr = pc;
    assign op             = instr[31:26];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BOOT;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            retire_cnt  <= '0;
        end else begin
            instr_valid <= 1'b0;
            case (state)
                S_BOOT: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem.imem_ack) begin
                        instr       <= imem.imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        pc         <= next_pc_f(pc, instr, Branch, Jump, Zero);
                        retire_cnt <= retire_cnt + CNT_W'(1);
                        state      <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

endmodule
